// File: rtl/nixie_pkg.sv
// Segment encodings, internal digit codes and helpers shared by the scan driver
// and its binary-to-BCD converter.
package nixie_pkg;

    // Active-low segment patterns {a,b,c,d,e,f,g,dp}; dp (bit 0) left dark here.
    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
        8'h49, 8'h41, 8'h1F, 8'h01, 8'h09
    };
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hFD;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_DASH  = 4'hE;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_SHIFT,
        CONV_COMMIT
    } conv_state_e;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    function automatic logic [7:0] bcd_to_seg(input logic [3:0] code, input logic dp);
        logic [7:0] s;
        s = SEG_BLANK;
        for (int k = 0; k < 10; k++) begin
            if (code == 4'(k)) begin
                s = SEG_DIGIT[k];
            end
        end
        if (code == BCD_DASH) begin
            s = SEG_DASH;
        end
        // A blank digit never shows a lone decimal point.
        if (dp && (code != BCD_BLANK)) begin
            s[0] = 1'b0;
        end
        return s;
    endfunction

endpackage

// File: rtl/nixie_bin2bcd.sv
// Sequential double-dabble converter: captures a binary value on start, shifts one
// bit per cycle, then presents BCD digits and an overflow flag for one done cycle.
module nixie_bin2bcd #(
    parameter int VAL_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [VAL_W-1:0]      value_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DIGITS*4-1:0]   bcd_o,
    output logic                  ovf_o
);
    import nixie_pkg::*;

    localparam int BCD_W = DIGITS * 4;
    localparam int CNT_W = $clog2(VAL_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(VAL_W - 1);
    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

    conv_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VAL_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic [BCD_W-1:0]   bcd_adj;

    // Add-3 correction on every nibble that would reach 10 or more after the shift.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                    (bcd_q[4*gi +: 4] + 4'd3) : bcd_q[4*gi +: 4];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            CONV_IDLE: begin
                if (start_i) begin
                    bin_d   = value_i;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = (64'(value_i) > MAX_VAL);
                    state_d = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                bcd_d = {bcd_adj[BCD_W-2:0], bin_q[VAL_W-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = CONV_COMMIT;
                end
            end
            CONV_COMMIT: begin
                state_d = CONV_IDLE;
            end
            default: begin
                state_d = CONV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CONV_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy_o = (state_q != CONV_IDLE);
    assign done_o = (state_q == CONV_COMMIT);
    assign bcd_o  = bcd_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/nixie_scan_driver.sv
// Multiplexed seven-segment driver: holds committed digits, applies leading-zero
// blanking and decimal points, and scans one digit per slot with a ghost gap.
module nixie_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int VAL_W    = 14,
    parameter int SCAN_DIV = 50000,
    parameter int GHOST    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [VAL_W-1:0]     value_i,
    input  logic                 load_i,
    input  logic                 blank_lz_i,
    input  logic [DIGITS-1:0]    dp_en_i,
    output logic [7:0]           seg_o,
    output logic [DIGITS-1:0]    dig_sel_o,
    output logic                 busy_o,
    output logic                 ovf_o
);
    import nixie_pkg::*;

    localparam int CNT_W  = $clog2(SCAN_DIV);
    localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  GHOST_C   = CNT_W'(GHOST);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(DIGITS - 1);

    logic                   conv_busy;
    logic                   conv_done;
    logic                   conv_ovf;
    logic [DIGITS*4-1:0]    conv_bcd;

    logic [3:0]             digit_q [DIGITS];
    logic                   ovf_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic [7:0]             seg_q, seg_d;
    logic [DIGITS-1:0]      dig_sel_q, dig_sel_d;
    logic [DIGITS-1:0]      blank_mask;
    logic [7:0]             render_seg [DIGITS];

    nixie_bin2bcd #(
        .VAL_W  (VAL_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (load_i),
        .value_i (value_i),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd),
        .ovf_o   (conv_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                digit_q[i] <= BCD_BLANK;
            end
            ovf_q <= 1'b0;
        end else if (conv_done) begin
            for (int i = 0; i < DIGITS; i++) begin
                digit_q[i] <= conv_ovf ? BCD_DASH : conv_bcd[4*i +: 4];
            end
            ovf_q <= conv_ovf;
        end
    end

    // Walk down from the top digit; the zero run ends at the first nonzero digit
    // or at any digit whose decimal point is lit.
    always_comb begin
        logic run;
        run        = 1'b1;
        blank_mask = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run           = run && (digit_q[i] == 4'd0) && !dp_en_i[i];
            blank_mask[i] = blank_lz_i && run && (i != 0);
        end
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_render
        assign render_seg[gi] = bcd_to_seg(blank_mask[gi] ? BCD_BLANK : digit_q[gi],
                                           dp_en_i[gi] && !ovf_q);
    end

    always_comb begin
        cnt_d     = (cnt_q == LAST_CNT) ? '0 : (cnt_q + CNT_W'(1));
        slot_d    = slot_q;
        seg_d     = SEG_BLANK;
        dig_sel_d = '1;
        if (cnt_q == LAST_CNT) begin
            slot_d = (slot_q == LAST_SLOT) ? '0 : (slot_q + SLOT_W'(1));
        end
        if (cnt_q >= GHOST_C) begin
            seg_d     = render_seg[slot_q];
            dig_sel_d = ~(DIGITS'(1) << slot_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            slot_q    <= '0;
            seg_q     <= SEG_BLANK;
            dig_sel_q <= '1;
        end else begin
            cnt_q     <= cnt_d;
            slot_q    <= slot_d;
            seg_q     <= seg_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    assign seg_o     = seg_q;
    assign dig_sel_o = dig_sel_q;
    assign busy_o    = conv_busy;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_nixie_scan_driver.sv
// Scoreboard bench for nixie_scan_driver: accepted loads are queued with their
// expected result; a negedge monitor checks conversions and every scanned output.
`timescale 1ns/1ps
module tb_nixie_scan_driver;

    localparam int DIGITS   = 4;
    localparam int VAL_W    = 14;
    localparam int SCAN_DIV = 8;
    localparam int GHOST    = 1;
    localparam int MAXV     = 9999;
    localparam int LEN      = VAL_W + 1;
    localparam int FRAME    = SCAN_DIV * DIGITS;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [VAL_W-1:0]   value = '0;
    logic               load = 1'b0;
    logic               blank_lz = 1'b0;
    logic [DIGITS-1:0]  dp_en = '0;
    logic [7:0]         seg;
    logic [DIGITS-1:0]  dig_sel;
    logic               busy;
    logic               ovf;

    nixie_scan_driver #(
        .DIGITS   (DIGITS),
        .VAL_W    (VAL_W),
        .SCAN_DIV (SCAN_DIV),
        .GHOST    (GHOST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_i    (value),
        .load_i     (load),
        .blank_lz_i (blank_lz),
        .dp_en_i    (dp_en),
        .seg_o      (seg),
        .dig_sel_o  (dig_sel),
        .busy_o     (busy),
        .ovf_o      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        bit ovf;
    } conv_t;

    conv_t      exp_q[$];
    int         checks = 0;
    int         errors = 0;
    bit [7:0]   seg_tab [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

    // Displayed content as the bench believes it is: nothing, a number, or overflow.
    bit         disp_valid = 1'b0;
    int         disp_val = 0;
    bit         disp_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_seg(input int i, input bit bl, input logic [DIGITS-1:0] dp);
        int place;
        int d;
        logic [7:0] s;
        place = 1;
        repeat (i) place = place * 10;
        if (!disp_valid) return 8'hFF;
        if (disp_ovf) return 8'hFD;
        d = (disp_val / place) % 10;
        if (bl && (i > 0) && (disp_val / place == 0) && ((dp >> i) == 0)) return 8'hFF;
        s = seg_tab[d];
        if (dp[i]) s[0] = 1'b0;
        return s;
    endfunction

    // Monitor: outputs registered at posedge N reflect the state during cycle N-1,
    // so the expectation for the next sample is formed from this cycle's state.
    logic [7:0]         exp_seg = 8'hFF;
    logic [DIGITS-1:0]  exp_dig = '1;
    int                 t = 0;
    int                 busy_len = 0;
    bit                 prev_busy = 1'b0;

    always @(negedge clk) begin
        conv_t c;
        int    cnt;
        int    slot;
        if (!rst_n) begin
            check("rst_seg", seg, 8'hFF);
            check("rst_dig_sel", dig_sel, 4'hF);
            check("rst_busy", busy, 0);
            check("rst_ovf", ovf, 0);
            t          = 0;
            busy_len   = 0;
            prev_busy  = 1'b0;
            disp_valid = 1'b0;
            disp_ovf   = 1'b0;
            exp_seg    = 8'hFF;
            exp_dig    = '1;
            exp_q.delete();
        end else begin
            check("seg", seg, exp_seg);
            check("dig_sel", dig_sel, exp_dig);
            if (busy) busy_len++;
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL conv_unexpected: got a conversion, expected none at %0t", $time);
                end else begin
                    c = exp_q.pop_front();
                    check("busy_len", busy_len, LEN);
                    check("ovf_commit", ovf, c.ovf);
                    disp_valid = 1'b1;
                    disp_val   = c.val;
                    disp_ovf   = c.ovf;
                    $display("commit value=%0d ovf=%0b busy_cycles=%0d", c.val, ovf, busy_len);
                end
                busy_len = 0;
            end
            check("ovf", ovf, disp_ovf);
            prev_busy = busy;
            cnt  = t % SCAN_DIV;
            slot = (t / SCAN_DIV) % DIGITS;
            t++;
            if (cnt < GHOST) begin
                exp_seg = 8'hFF;
                exp_dig = '1;
            end else begin
                exp_seg = model_seg(slot, blank_lz, dp_en);
                exp_dig = ~(4'b0001 << slot);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_load(input int v, input bit accept);
        conv_t e;
        value = VAL_W'(v);
        load  = 1'b1;
        if (accept) begin
            e.val = v;
            e.ovf = (v > MAXV);
            exp_q.push_back(e);
        end
        $display("load value=%0d blank_lz=%0b dp_en=%b expect_accept=%0b", v, blank_lz, dp_en, accept);
        cycles(1);
        load = 1'b0;
    endtask

    task automatic settle();
        cycles(LEN + 2 + FRAME + 4);
    endtask

    initial begin
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(FRAME + 2);

        do_load(1234, 1'b1);
        settle();

        blank_lz = 1'b1;
        do_load(7, 1'b1);
        settle();
        blank_lz = 1'b0;
        cycles(FRAME + 2);

        do_load(12000, 1'b1);
        settle();
        do_load(5, 1'b1);
        settle();

        blank_lz = 1'b1;
        dp_en    = 4'b0100;
        do_load(5, 1'b1);
        settle();
        dp_en = '0;
        do_load(0, 1'b1);
        settle();
        blank_lz = 1'b0;

        do_load(9999, 1'b1);
        settle();
        do_load(10000, 1'b1);
        settle();

        do_load(42, 1'b1);
        do_load(99, 1'b0);
        settle();

        do_load(8765, 1'b1);
        cycles(4);
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(FRAME + 2);

        for (int k = 0; k < 40; k++) begin
            int v;
            v = (k % 4 == 0) ? int'($urandom_range(9990, 10010))
                             : int'($urandom_range(0, (1 << VAL_W) - 1));
            blank_lz = 1'($urandom_range(0, 1));
            dp_en    = DIGITS'($urandom_range(0, (1 << DIGITS) - 1));
            do_load(v, 1'b1);
            if ($urandom_range(0, 2) == 0) begin
                cycles($urandom_range(0, 13));
                do_load(int'($urandom_range(0, (1 << VAL_W) - 1)), 1'b0);
            end
            cycles(LEN + 1);
            cycles($urandom_range(0, 10));
            if ($urandom_range(0, 1) == 1) blank_lz = ~blank_lz;
            cycles(FRAME + 2);
        end

        check("queue_empty", exp_q.size(), 0);
        check("busy_end", busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nixie_scan_driver.md
Name: nixie_scan_driver

Overview:
- Next-generation seven-segment driver: takes a binary value, converts it to BCD over several cycles, and time-multiplexes DIGITS common digits onto one shared segment bus.
- Adds leading-zero blanking, per-digit decimal point, overflow indication and anti-ghosting blanking.
- Sits between the PWM rate/control logic and the board display pins, replacing the single-digit combinational decoder.

Parameters:
- DIGITS, 4: number of multiplexed digits, 1..8.
- VAL_W, 14: width of binary input value; must satisfy 2^VAL_W ≥ 10^DIGITS.
- SCAN_DIV, 50000: clk cycles per digit slot; must be ≥ 2.
- GHOST, 16: blanked cycles at the start of each slot; must be < SCAN_DIV.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- value  in  VAL_W  binary number to display
- load  in  1  one-cycle request to convert and display value
- blank_lz  in  1  1 = blank leading zeros
- dp_en  in  DIGITS  bit i lights the decimal point of digit i
- seg  out  8  segments {a,b,c,d,e,f,g,dp}, bit7=a, bit0=dp, active-low (0 = lit)
- dig_sel  out  DIGITS  digit enables, active-low, one-hot-low; bit 0 = least significant digit
- busy  out  1  conversion in progress
- ovf  out  1  last accepted value exceeded 10^DIGITS−1

Behaviour:
- Reset (async, rst_n=0): seg=8'hFF, dig_sel=all ones, busy=0, ovf=0, every digit register holds the BLANK code, scan counter=0, slot index=0. If asserted mid-conversion, the conversion is discarded.
- Accept: load=1 at edge E0 with busy=0 captures value; busy=1 after E0. load while busy=1 is ignored; no queueing.
- Conversion: sequential shift-add-3, one bit per edge on E1..E_VAL_W.
- Commit at E_{VAL_W+1}: digit registers updated, ovf updated, busy=0. Busy is high for exactly VAL_W+1 cycles.
- Overflow: if the captured value > 10^DIGITS−1, all digit registers are set to DASH, ovf=1, and dp is suppressed. Otherwise ovf=0 and the BCD digits are stored.
- Blanking is evaluated at render time from the current blank_lz and dp_en:
  - with blank_lz=1, digit i>0 is blank if it and all higher digits are 0;
  - blanking stops at the highest digit with dp_en set;
  - digit 0 is never blanked by this rule.
- Segment codes: 0..9 = 03,9F,25,0D,99,49,41,1F,01,09 (hex), BLANK=FF, DASH=FD. The dp bit is cleared when dp_en[i]=1 and the digit is not BLANK.
- Scan: free-running counter 0..SCAN_DIV−1. On wrap, the slot index increments, DIGITS−1 wraps to 0.
  - Counter < GHOST: seg=FF and dig_sel=all ones.
  - Otherwise: dig_sel drives bit[index] low, and seg shows the rendered code of digit index.
  - seg and dig_sel are registered (one-cycle latency from counter/digit state).
- Simultaneous commit and slot change: the new digit content is visible from the next cycle; no tearing protection beyond that.
- Scanning continues uninterrupted during conversion, showing the old content.

Decomposition:
- Package nixie_pkg:
  - segment constants SEG_DIGIT[0:9], SEG_BLANK, SEG_DASH;
  - 4-bit codes BCD_BLANK=4'hF, BCD_DASH=4'hE;
  - function bcd_to_seg(code, dp).
- Sub-module nixie_bin2bcd (VAL_W, DIGITS): start/busy/done handshake, sequential double-dabble, ovf compare.
- The top level holds the digit registers, blanking, and the scan/ghost counter.

Test Plan (DIGITS=4, VAL_W=14, SCAN_DIV=8, GHOST=1):
- Reset: hold rst_n=0 → seg=FF, dig_sel=1111, busy=0, ovf=0. Release and scan one frame → seg=FF in every slot.
- load value=1234, blank_lz=0, dp_en=0 → busy high exactly 15 cycles. Then per slot:
  - dig_sel=1110 → seg=99
  - dig_sel=1101 → seg=0D
  - dig_sel=1011 → seg=25
  - dig_sel=0111 → seg=9F
  - first cycle of each slot: seg=FF, dig_sel=1111.
- load value=7:
  - blank_lz=1 → digits 3..1 seg=FF, digit0 seg=1F;
  - switch to blank_lz=0 → digits 3..1 seg=03.
- load value=12000 → ovf=1, all digits seg=FD. Then load 5 → ovf=0, digit0 seg=49.
- load value=5, blank_lz=1, dp_en=0100 → digit3 seg=FF, digit2 seg=02, digit1 seg=03, digit0 seg=49.
- Busy and reset during operation:
  - load 42, then load 99 on the next cycle → display shows 42, and the second load is ignored;
  - rst_n pulsed low at cycle 5 of a conversion → all outputs immediately at reset values, display blank, busy=0.
